// File: rtl/data_mem.sv
// data_mem: word-organised data memory for the single-cycle CPU datapath.
//
// Synchronous 32-bit stores, combinational 32-bit loads, contents cleared
// by an asynchronous active-high reset.
//
// Parameters:
//   DEPTH   number of 32-bit words (power of two, >= 4)
//   AW      word-index width, derived as $clog2(DEPTH)
//
// Ports:
//   clk     rising-edge clock for all writes
//   rst     asynchronous active-high reset, clears the whole array
//   we_DM   write enable, sampled on the rising edge of clk
//   dataDM  32-bit write data
//   addDM   32-bit byte address; word index is addDM[AW+1:2]
//   outDM   32-bit combinational read data for addDM
//
// Optional feature: define DATAMEM_ALIGN_CHECK_EN to suppress writes and
// return zero on reads whose addDM[1:0] is non-zero. Without it the low
// two address bits are ignored.
module data_mem #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_DM,
    input  logic [31:0] dataDM,
    input  logic [31:0] addDM,
    output logic [31:0] outDM
);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic          aligned;

    assign idx = addDM[AW+1:2];

`ifdef DATAMEM_ALIGN_CHECK_EN
    assign aligned = addDM[1:0] == 2'b00;
    logic unused_addr;
    assign unused_addr = ^addDM[31:AW+2];
`else
    // Low bits force word alignment, high bits alias modulo DEPTH*4 bytes.
    assign aligned = 1'b1;
    logic unused_addr;
    assign unused_addr = ^{addDM[31:AW+2], addDM[1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_DM && aligned) begin
            mem_q[idx] <= dataDM;
        end
    end

    // No write-through: a same-word write only shows after the edge.
    assign outDM = aligned ? mem_q[idx] : 32'h0;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: table-driven self-checking bench for data_mem.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_DM;
    logic [31:0] dataDM;
    logic [31:0] addDM;
    logic [31:0] outDM;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DATAMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    data_mem #(.DEPTH(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .we_DM (we_DM),
        .dataDM(dataDM),
        .addDM (addDM),
        .outDM (outDM)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] exp_pre;
        logic [31:0] exp_post;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addDM = a;
        #1;
        check(name, outDM, exp);
    endtask

    initial begin
        rst = 1'b1;
        we_DM = 1'b0;
        dataDM = '0;
        addDM = '0;
        #1;
        read_check("reset_init_a0", 32'd0, 32'h0);
        read_check("reset_init_a252", 32'd252, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{"wr_8", 1, 32'hABCDEFFF, 32'd8, 32'h0, 32'hABCDEFFF});
        vecs.push_back('{"rd_8", 0, 32'h0, 32'd8, 32'hABCDEFFF, 32'hABCDEFFF});
        vecs.push_back('{"wr_16", 1, 32'h12345678, 32'd16, 32'h0, 32'h12345678});
        vecs.push_back('{"rd_8_again", 0, 32'h0, 32'd8, 32'hABCDEFFF, 32'hABCDEFFF});
        vecs.push_back('{"we0_16", 0, 32'hDEADBEEF, 32'd16, 32'h12345678, 32'h12345678});
        vecs.push_back('{"wr_4", 1, 32'hCAFEF00D, 32'd4, 32'h0, 32'hCAFEF00D});
        vecs.push_back('{"alias_260", 0, 32'h0, 32'd260, 32'hCAFEF00D, 32'hCAFEF00D});
        vecs.push_back('{"misal_rd_6", 0, 32'h0, 32'd6,
                         ALIGN ? 32'h0 : 32'hCAFEF00D, ALIGN ? 32'h0 : 32'hCAFEF00D});
        vecs.push_back('{"rdw_8", 1, 32'h0F0F0F0F, 32'd8, 32'hABCDEFFF, 32'h0F0F0F0F});
        vecs.push_back('{"misal_wr_6", 1, 32'h11111111, 32'd6,
                         ALIGN ? 32'h0 : 32'hCAFEF00D, ALIGN ? 32'h0 : 32'h11111111});
        vecs.push_back('{"rd_4_after_misal", 0, 32'h0, 32'd4,
                         ALIGN ? 32'hCAFEF00D : 32'h11111111, ALIGN ? 32'hCAFEF00D : 32'h11111111});
        vecs.push_back('{"alias_wr_272", 1, 32'h22222222, 32'd272, 32'h12345678, 32'h22222222});
        vecs.push_back('{"rd_16_alias", 0, 32'h0, 32'd16, 32'h22222222, 32'h22222222});
        vecs.push_back('{"wr_252", 1, 32'h33333333, 32'd252, 32'h0, 32'h33333333});
        vecs.push_back('{"alias_top", 0, 32'h0, 32'hFFFFFFFC, 32'h33333333, 32'h33333333});

        foreach (vecs[i]) begin
            we_DM = vecs[i].we;
            dataDM = vecs[i].data;
            addDM = vecs[i].addr;
            #1;
            check({vecs[i].name, "_pre"}, outDM, vecs[i].exp_pre);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_post"}, outDM, vecs[i].exp_post);
            we_DM = 1'b0;
            @(negedge clk);
        end

        // Asynchronous reset mid-operation with a write pending.
        we_DM = 1'b1;
        dataDM = 32'h44444444;
        addDM = 32'd8;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a8", outDM, 32'h0);
        read_check("async_rst_a0", 32'd0, 32'h0);
        read_check("async_rst_a16", 32'd16, 32'h0);
        read_check("async_rst_a252", 32'd252, 32'h0);
        addDM = 32'd8;
        @(posedge clk);
        #1;
        check("rst_edge_no_write", outDM, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dataDM = 32'h55555555;
        @(posedge clk);
        #1;
        check("first_write_after_rst", outDM, 32'h55555555);
        we_DM = 1'b0;
        read_check("post_rst_a16_clear", 32'd16, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/data_mem.md
# data_mem

Word-organised data memory for the single-cycle CPU datapath, sitting behind the load/store unit. It is addressed by the byte address produced by the ALU. Stores are synchronous 32-bit writes; loads are combinational 32-bit reads. All contents clear on reset so program-visible data starts at a known state.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; must be a power of two, at least 4.
- AW, log2(DEPTH): word-index width, derived from DEPTH and not overridden separately.

Ports:
- clk  in  1: rising-edge clock for all writes.
- rst  in  1: reset, asynchronous and active-high; clears the entire array.
- we_DM  in  1: write enable, sampled on the rising edge of clk.
- dataDM  in  32: write data.
- addDM  in  32: byte address.
- outDM  out  32: read data for addDM.

## Operation
- Storage is DEPTH x 32-bit registers, mem[0..DEPTH-1].
- Word index is addDM[AW+1:2].
  - addDM[1:0] is ignored, so accesses are forced to word alignment.
  - addDM[31:AW+2] is ignored, so addresses alias modulo DEPTH*4 bytes.
- Write:
  - Condition: rising edge of clk with we_DM=1 and rst=0.
  - Effect: mem[index] <= dataDM, a full 32-bit write with no byte enables.
- Read: outDM = mem[index], purely combinational from addDM and the array contents. It is independent of we_DM.
- With we_DM=0, a clock edge changes nothing.
- Reset: while rst=1, every word is 0, so outDM=0 for any address. Writes are ignored while rst is asserted.
- No X on outDM after the first reset, for any addDM value, including misaligned or out-of-range addresses.

## Timing
- Write latency: 1 edge. Data written at edge N is visible on outDM immediately after edge N, provided addDM still selects the same word.
- Read-during-write to the same word:
  - Before the edge, outDM shows the old data.
  - After the edge, outDM shows the new data.
  - There is no write-through bypass.
- Read latency: 0 cycles, combinational from addDM.
- rst assertion takes effect immediately, without waiting for clk. An edge coinciding with rst=1 performs no write.
- rst deassertion: the first edge that sees rst=0 and we_DM=1 performs a write.
- Reset mid-operation: any write pending on the same edge as reset assertion is dropped, and the array reads all-zero.

## Configuration
- Macro: DATAMEM_ALIGN_CHECK_EN.
- Defined:
  - A write whose addDM[1:0] != 0 is suppressed, leaving the memory unchanged.
  - A read whose addDM[1:0] != 0 returns 32'h00000000.
  - Aligned accesses behave exactly as in the undefined case.
- Undefined (default): addDM[1:0] is ignored for both read and write, as described under Operation.

## Test plan
- Reset: assert rst mid-simulation after several writes. Required: outDM=0 at addresses 0, 8, 16 and 252, without waiting for a clock edge.
- Write/read: we_DM=1, dataDM=32'hABCDEFFF, addDM=8, one edge. Then we_DM=0, addDM=8. Required: outDM=32'hABCDEFFF.
- Second word:
  - Stimulus: write 32'h12345678 at addDM=16.
  - Required: reading addDM=16 gives 32'h12345678, and addDM=8 still gives 32'hABCDEFFF.
- Write disabled: we_DM=0, dataDM=32'hDEADBEEF, addDM=16, one edge. Required: addDM=16 still reads 32'h12345678.
- Aliasing/alignment, with DEPTH=64 and the macro undefined:
  - Stimulus: write 32'hCAFEF00D at addDM=4.
  - Required: addDM=260 and addDM=6 both read 32'hCAFEF00D.
  - With DATAMEM_ALIGN_CHECK_EN defined: addDM=6 reads 0, and a write to addDM=6 leaves word 1 unchanged.
- Read-during-write:
  - Stimulus: addDM=8 holds 32'hABCDEFFF; apply we_DM=1 with dataDM=32'h0F0F0F0F.
  - Required: outDM=32'hABCDEFFF before the edge and 32'h0F0F0F0F after it.
